// File: rtl/atm_session_ctrl_pkg.sv
// Shared op codes, status codes, FSM state encodings and misc constants
// for the ATM session controller and its account store.
package atm_session_ctrl_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic ENGLISH = 1'b0;
  localparam logic ARABIC  = 1'b1;

  localparam logic [2:0] OP_LOGIN      = 3'd0;
  localparam logic [2:0] OP_BALANCE    = 3'd1;
  localparam logic [2:0] OP_WITHDRAW   = 3'd2;
  localparam logic [2:0] OP_DEPOSIT    = 3'd3;
  localparam logic [2:0] OP_CHANGE_PIN = 3'd4;
  localparam logic [2:0] OP_EXIT       = 3'd5;

  localparam logic [2:0] ST_OK           = 3'd0;
  localparam logic [2:0] ST_BAD_PIN      = 3'd1;
  localparam logic [2:0] ST_NO_ACCOUNT   = 3'd2;
  localparam logic [2:0] ST_LOCKED       = 3'd3;
  localparam logic [2:0] ST_INSUFFICIENT = 3'd4;
  localparam logic [2:0] ST_OVERFLOW     = 3'd5;
  localparam logic [2:0] ST_BAD_OP       = 3'd6;
  localparam logic [2:0] ST_TIMEOUT      = 3'd7;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_SESSION = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

endpackage

// File: rtl/atm_account_store.sv
// Per-account balance, PIN, fail counter and lock bit storage.
// One combinational read port, one write port; reset restores initial values.
module atm_account_store
  import atm_session_ctrl_pkg::*;
#(
  parameter int                 NUM_ACCOUNTS = 10,
  parameter int                 ACC_W        = 4,
  parameter int                 BAL_W        = 16,
  parameter int                 PIN_W        = 16,
  parameter int                 INIT_BALANCE = 500,
  parameter logic [PIN_W-1:0]   INIT_PIN     = 16'h1234,
  parameter int                 MAX_ATTEMPTS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ACC_W-1:0]        rd_idx,
  output logic [BAL_W-1:0]        rd_balance,
  output logic [PIN_W-1:0]        rd_pin,
  output logic                    rd_locked,
  input  logic [ACC_W-1:0]        wr_idx,
  input  logic                    wr_bal_en,
  input  logic [BAL_W-1:0]        wr_bal,
  input  logic                    wr_pin_en,
  input  logic [PIN_W-1:0]        wr_pin,
  input  logic                    wr_fail_inc,
  input  logic                    wr_fail_clr,
  output logic [NUM_ACCOUNTS-1:0] lock_vec
);

  localparam logic [BAL_W-1:0] INIT_BAL_L = BAL_W'(INIT_BALANCE);
  localparam logic [ACC_W:0]   NUM_ACC_L  = (ACC_W+1)'(NUM_ACCOUNTS);
  localparam logic [2:0]       MAX_L      = 3'(MAX_ATTEMPTS);

  logic [NUM_ACCOUNTS-1:0][BAL_W-1:0] bal_vec;
  logic [NUM_ACCOUNTS-1:0][PIN_W-1:0] pin_vec;
  logic                               rd_in_range;

  for (genvar g = 0; g < NUM_ACCOUNTS; g++) begin : g_acc
    logic [BAL_W-1:0] bal_q, bal_d;
    logic [PIN_W-1:0] pin_q, pin_d;
    logic [2:0]       fail_q, fail_d;
    logic             lock_q, lock_d;
    logic             hit;

    assign hit = (wr_idx == ACC_W'(g));

    always_comb begin
      bal_d  = bal_q;
      pin_d  = pin_q;
      fail_d = fail_q;
      lock_d = lock_q;
      if (hit) begin
        if (wr_bal_en) bal_d = wr_bal;
        if (wr_pin_en) pin_d = wr_pin;
        if (wr_fail_clr) begin
          fail_d = '0;
        end else if (wr_fail_inc && !lock_q) begin
          // Lock on the attempt that brings the count up to the limit
          fail_d = fail_q + 3'd1;
          if (fail_q + 3'd1 == MAX_L) lock_d = TRUE;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bal_q  <= INIT_BAL_L;
        pin_q  <= INIT_PIN;
        fail_q <= '0;
        lock_q <= FALSE;
      end else begin
        bal_q  <= bal_d;
        pin_q  <= pin_d;
        fail_q <= fail_d;
        lock_q <= lock_d;
      end
    end

    assign bal_vec[g]  = bal_q;
    assign pin_vec[g]  = pin_q;
    assign lock_vec[g] = lock_q;
  end

  assign rd_in_range = ({1'b0, rd_idx} < NUM_ACC_L);
  assign rd_balance  = rd_in_range ? bal_vec[rd_idx]  : '0;
  assign rd_pin      = rd_in_range ? pin_vec[rd_idx]  : '0;
  assign rd_locked   = rd_in_range ? lock_vec[rd_idx] : FALSE;

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM login/session controller with valid/ready request port and one-cycle
// response pulse. Optional idle-session timeout under ATM_SESSION_TIMEOUT_EN.
module atm_session_ctrl
  import atm_session_ctrl_pkg::*;
#(
  parameter int               NUM_ACCOUNTS = 10,
  parameter int               ACC_W        = 4,
  parameter int               BAL_W        = 16,
  parameter int               PIN_W        = 16,
  parameter int               INIT_BALANCE = 500,
  parameter logic [PIN_W-1:0] INIT_PIN     = 16'h1234,
  parameter int               MAX_ATTEMPTS = 3,
  parameter int               TIMEOUT_CYC  = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [2:0]              req_op,
  input  logic [ACC_W-1:0]        req_acc,
  input  logic [PIN_W-1:0]        req_pin,
  input  logic [BAL_W-1:0]        req_amount,
  output logic                    rsp_valid,
  output logic [2:0]              rsp_status,
  output logic [BAL_W-1:0]        rsp_balance,
  output logic                    session_active,
  output logic [NUM_ACCOUNTS-1:0] lock_vec
);

  if (MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 7) begin : g_bad_attempts
    $error("MAX_ATTEMPTS out of range 1..7");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  typedef struct packed {
    logic [2:0]       op;
    logic [ACC_W-1:0] acc;
    logic [PIN_W-1:0] pin;
    logic [BAL_W-1:0] amount;
  } req_t;

  localparam logic [ACC_W:0] NUM_ACC_L = (ACC_W+1)'(NUM_ACCOUNTS);

  logic [2:0]       state_q, state_d;
  req_t             req_q, req_d, req_in;
  logic             sess_act_q, sess_act_d;
  logic [ACC_W-1:0] sess_acc_q, sess_acc_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [2:0]       rsp_status_q, rsp_status_d;
  logic [BAL_W-1:0] rsp_balance_q, rsp_balance_d;

  logic             accept;
  logic             tmo_expire;
  logic [ACC_W-1:0] st_idx;
  logic [BAL_W-1:0] rd_balance;
  logic [PIN_W-1:0] rd_pin;
  logic             rd_locked;
  logic             wr_bal_en, wr_pin_en, wr_fail_inc, wr_fail_clr;
  logic [BAL_W-1:0] wr_bal;
  logic [BAL_W:0]   dep_sum;

  assign req_ready = rst_n & ((state_q == S_IDLE) | (state_q == S_SESSION));
  assign accept    = req_valid & req_ready;
  assign req_in    = '{op: req_op, acc: req_acc, pin: req_pin, amount: req_amount};

  // CHECK looks at the account being logged into; everything else at the session account
  assign st_idx  = (state_q == S_CHECK) ? req_q.acc : sess_acc_q;
  assign dep_sum = {1'b0, rd_balance} + {1'b0, req_q.amount};

  atm_account_store #(
    .NUM_ACCOUNTS (NUM_ACCOUNTS),
    .ACC_W        (ACC_W),
    .BAL_W        (BAL_W),
    .PIN_W        (PIN_W),
    .INIT_BALANCE (INIT_BALANCE),
    .INIT_PIN     (INIT_PIN),
    .MAX_ATTEMPTS (MAX_ATTEMPTS)
  ) u_store (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_idx      (st_idx),
    .rd_balance  (rd_balance),
    .rd_pin      (rd_pin),
    .rd_locked   (rd_locked),
    .wr_idx      (st_idx),
    .wr_bal_en   (wr_bal_en),
    .wr_bal      (wr_bal),
    .wr_pin_en   (wr_pin_en),
    .wr_pin      (req_q.pin),
    .wr_fail_inc (wr_fail_inc),
    .wr_fail_clr (wr_fail_clr),
    .lock_vec    (lock_vec)
  );

`ifdef ATM_SESSION_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // An accept in the expiring cycle wins: the counter only advances on idle SESSION cycles
  always_comb begin
    tmo_cnt_d  = '0;
    tmo_expire = FALSE;
    if (state_q == S_SESSION && !accept) begin
      tmo_cnt_d  = tmo_cnt_q + 1'b1;
      tmo_expire = (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_expire = FALSE;
`endif

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    sess_act_d    = sess_act_q;
    sess_acc_d    = sess_acc_q;
    rsp_valid_d   = FALSE;
    rsp_status_d  = rsp_status_q;
    rsp_balance_d = rsp_balance_q;
    wr_bal_en     = FALSE;
    wr_bal        = rd_balance;
    wr_pin_en     = FALSE;
    wr_fail_inc   = FALSE;
    wr_fail_clr   = FALSE;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          req_d = req_in;
          if (req_in.op == OP_LOGIN) begin
            state_d = S_CHECK;
          end else begin
            state_d       = S_RESP;
            rsp_valid_d   = TRUE;
            rsp_status_d  = (req_in.op == OP_EXIT) ? ST_OK : ST_BAD_OP;
            rsp_balance_d = '0;
          end
        end
      end

      S_CHECK: begin
        state_d       = S_RESP;
        rsp_valid_d   = TRUE;
        rsp_balance_d = '0;
        if ({1'b0, req_q.acc} >= NUM_ACC_L) begin
          rsp_status_d = ST_NO_ACCOUNT;
        end else if (rd_locked) begin
          rsp_status_d = ST_LOCKED;
        end else if (rd_pin != req_q.pin) begin
          rsp_status_d = ST_BAD_PIN;
          wr_fail_inc  = TRUE;
        end else begin
          rsp_status_d  = ST_OK;
          wr_fail_clr   = TRUE;
          sess_act_d    = TRUE;
          sess_acc_d    = req_q.acc;
          rsp_balance_d = rd_balance;
        end
      end

      S_SESSION: begin
        if (accept) begin
          req_d = req_in;
          case (req_in.op)
            OP_BALANCE, OP_WITHDRAW, OP_DEPOSIT, OP_CHANGE_PIN: state_d = S_EXEC;
            OP_EXIT: begin
              state_d       = S_RESP;
              rsp_valid_d   = TRUE;
              rsp_status_d  = ST_OK;
              rsp_balance_d = '0;
              sess_act_d    = FALSE;
            end
            default: begin
              state_d       = S_RESP;
              rsp_valid_d   = TRUE;
              rsp_status_d  = ST_BAD_OP;
              rsp_balance_d = rd_balance;
            end
          endcase
        end else if (tmo_expire) begin
          state_d       = S_RESP;
          rsp_valid_d   = TRUE;
          rsp_status_d  = ST_TIMEOUT;
          rsp_balance_d = '0;
          sess_act_d    = FALSE;
        end
      end

      S_EXEC: begin
        state_d       = S_RESP;
        rsp_valid_d   = TRUE;
        rsp_status_d  = ST_OK;
        rsp_balance_d = rd_balance;
        case (req_q.op)
          OP_WITHDRAW: begin
            if (req_q.amount > rd_balance) begin
              rsp_status_d = ST_INSUFFICIENT;
            end else begin
              wr_bal_en     = TRUE;
              wr_bal        = rd_balance - req_q.amount;
              rsp_balance_d = wr_bal;
            end
          end
          OP_DEPOSIT: begin
            if (dep_sum[BAL_W]) begin
              rsp_status_d = ST_OVERFLOW;
            end else begin
              wr_bal_en     = TRUE;
              wr_bal        = dep_sum[BAL_W-1:0];
              rsp_balance_d = wr_bal;
            end
          end
          OP_CHANGE_PIN: wr_pin_en = TRUE;
          default: ;
        endcase
      end

      S_RESP:  state_d = sess_act_q ? S_SESSION : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      req_q         <= '0;
      sess_act_q    <= FALSE;
      sess_acc_q    <= '0;
      rsp_valid_q   <= FALSE;
      rsp_status_q  <= '0;
      rsp_balance_q <= '0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      sess_act_q    <= sess_act_d;
      sess_acc_q    <= sess_acc_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_status_q  <= rsp_status_d;
      rsp_balance_q <= rsp_balance_d;
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_status     = rsp_status_q;
  assign rsp_balance    = rsp_balance_q;
  assign session_active = sess_act_q &
                          ((state_q == S_SESSION) | (state_q == S_EXEC) | (state_q == S_RESP));

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed table-driven bench for atm_session_ctrl plus hand sequences for
// idle-session behaviour and reset in the middle of an operation.
module tb_atm_session_ctrl;

  localparam logic [2:0] LOGIN = 3'd0, BAL = 3'd1, WD = 3'd2, DEP = 3'd3, CP = 3'd4, EXT = 3'd5;
  localparam logic [2:0] OK = 3'd0, BPIN = 3'd1, NOACC = 3'd2, LOCKD = 3'd3,
                         INSUF = 3'd4, OVF = 3'd5, BADOP = 3'd6, TMO = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [3:0]  req_acc = '0;
  logic [15:0] req_pin = '0;
  logic [15:0] req_amount = '0;
  logic        rsp_valid;
  logic [2:0]  rsp_status;
  logic [15:0] rsp_balance;
  logic        session_active;
  logic [9:0]  lock_vec;

  int n_tests = 0;
  int n_fail  = 0;

  atm_session_ctrl #(.TIMEOUT_CYC(20)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_acc        (req_acc),
    .req_pin        (req_pin),
    .req_amount     (req_amount),
    .rsp_valid      (rsp_valid),
    .rsp_status     (rsp_status),
    .rsp_balance    (rsp_balance),
    .session_active (session_active),
    .lock_vec       (lock_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  acc;
    logic [15:0] pin;
    logic [15:0] amt;
    logic [2:0]  st;
    logic [15:0] bal;
    logic        sa;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [2:0] op, input logic [3:0] acc, input logic [15:0] pin,
                     input logic [15:0] amt, input logic [2:0] st, input logic [15:0] bal,
                     input logic sa, input int lat);
    vec_t v;
    v.op = op; v.acc = acc; v.pin = pin; v.amt = amt;
    v.st = st; v.bal = bal; v.sa = sa; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request, scramble the inputs right after acceptance, and
  // return the response fields plus the accept-to-rsp_valid latency.
  task automatic do_req(input logic [2:0] op, input logic [3:0] acc, input logic [15:0] pin,
                        input logic [15:0] amt, output logic [2:0] st, output logic [15:0] bal,
                        output logic sa, output int lat);
    int w;
    st = '0; bal = '0; sa = 1'b0; lat = 99;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_acc = acc; req_pin = pin; req_amount = amt;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      check("req_ready_wait", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_op = 3'd7; req_acc = ~acc; req_pin = ~pin; req_amount = ~amt;
      for (int i = 1; i <= 8 && lat == 99; i++) begin
        @(negedge clk);
        if (rsp_valid) begin
          lat = i; st = rsp_status; bal = rsp_balance; sa = session_active;
        end
      end
      if (lat != 99) begin
        @(negedge clk);
        check("rsp_pulse_width", 32'(rsp_valid), 32'd0);
      end
    end
  endtask

  initial begin
    logic [2:0]  st;
    logic [15:0] bal;
    logic        sa;
    int          lat;
    int          cyc;

    // Reset state
    #12;
    check("rst_ready",   32'(req_ready), 32'd0);
    check("rst_rsp",     32'(rsp_valid), 32'd0);
    check("rst_session", 32'(session_active), 32'd0);
    check("rst_lock",    32'(lock_vec), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready), 32'd1);

    add(LOGIN, 2, 16'h1234, 0,     OK,    500,   1, 2);
    add(BAL,   0, 0,        0,     OK,    500,   1, 2);
    add(WD,    0, 0,        200,   OK,    300,   1, 2);
    add(WD,    0, 0,        400,   INSUF, 300,   1, 2);
    add(DEP,   0, 0,        200,   OK,    500,   1, 2);
    add(DEP,   0, 0,        65036, OVF,   500,   1, 2);
    add(DEP,   0, 0,        100,   OK,    600,   1, 2);
    add(DEP,   0, 0,        0,     OK,    600,   1, 2);
    add(WD,    0, 0,        600,   OK,    0,     1, 2);
    add(DEP,   0, 0,        65535, OK,    65535, 1, 2);
    add(DEP,   0, 0,        1,     OVF,   65535, 1, 2);
    add(WD,    0, 0,        65535, OK,    0,     1, 2);
    add(DEP,   0, 0,        500,   OK,    500,   1, 2);
    add(LOGIN, 3, 16'h1234, 0,     BADOP, 500,   1, 1);
    add(CP,    0, 16'h0042, 0,     OK,    500,   1, 2);
    add(EXT,   0, 0,        0,     OK,    0,     0, 1);
    add(LOGIN, 2, 16'h1234, 0,     BPIN,  0,     0, 2);
    add(LOGIN, 2, 16'h0042, 0,     OK,    500,   1, 2);
    add(EXT,   0, 0,        0,     OK,    0,     0, 1);
    add(BAL,   0, 0,        0,     BADOP, 0,     0, 1);
    add(LOGIN, 2, 16'h1111, 0,     BPIN,  0,     0, 2);
    add(LOGIN, 2, 16'h1111, 0,     BPIN,  0,     0, 2);
    add(LOGIN, 2, 16'h0042, 0,     OK,    500,   1, 2);
    add(EXT,   0, 0,        0,     OK,    0,     0, 1);
    add(LOGIN, 4, 16'h9999, 0,     BPIN,  0,     0, 2);
    add(LOGIN, 4, 16'h9999, 0,     BPIN,  0,     0, 2);
    add(LOGIN, 4, 16'h9999, 0,     BPIN,  0,     0, 2);
    add(LOGIN, 4, 16'h1234, 0,     LOCKD, 0,     0, 2);
    add(LOGIN, 12, 16'h1234, 0,    NOACC, 0,     0, 2);
    add(LOGIN, 10, 16'h1234, 0,    NOACC, 0,     0, 2);
    add(LOGIN, 9, 16'h1234, 0,     OK,    500,   1, 2);
    add(EXT,   0, 0,        0,     OK,    0,     0, 1);

    foreach (vecs[k]) begin
      do_req(vecs[k].op, vecs[k].acc, vecs[k].pin, vecs[k].amt, st, bal, sa, lat);
      check($sformatf("v%0d_latency", k), 32'(lat), 32'(vecs[k].lat));
      check($sformatf("v%0d_status",  k), 32'(st),  32'(vecs[k].st));
      check($sformatf("v%0d_balance", k), 32'(bal), 32'(vecs[k].bal));
      check($sformatf("v%0d_session", k), 32'(sa),  32'(vecs[k].sa));
    end
    check("lock_vec_acc4", 32'(lock_vec), 32'h010);

    // Idle session behaviour
    do_req(LOGIN, 0, 16'h1234, 0, st, bal, sa, lat);
    check("idle_login", 32'(st), 32'(OK));
`ifdef ATM_SESSION_TIMEOUT_EN
    cyc = 0;
    for (int i = 1; i <= 30 && cyc == 0; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        cyc = i; st = rsp_status; sa = session_active;
      end
    end
    check("tmo_cycles",  32'(cyc), 32'd20);
    check("tmo_status",  32'(st),  32'(TMO));
    check("tmo_session", 32'(sa),  32'd0);
    @(negedge clk);
    check("tmo_idle_ready", 32'(req_ready), 32'd1);
`else
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rsp_valid) cyc++;
    end
    check("no_tmo_rsp",     32'(cyc), 32'd0);
    check("no_tmo_session", 32'(session_active), 32'd1);
    do_req(EXT, 0, 0, 0, st, bal, sa, lat);
    check("no_tmo_exit", 32'(st), 32'(OK));
`endif

    // Reset asserted while a WITHDRAW is in EXEC
    do_req(LOGIN, 0, 16'h1234, 0, st, bal, sa, lat);
    do_req(WD, 0, 0, 100, st, bal, sa, lat);
    check("pre_rst_withdraw", 32'(bal), 32'd400);
    @(negedge clk);
    req_valid = 1'b1; req_op = WD; req_amount = 16'd50;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid",  32'(rsp_valid), 32'd0);
    check("mid_rst_rsp_status", 32'(rsp_status), 32'd0);
    check("mid_rst_rsp_bal",    32'(rsp_balance), 32'd0);
    check("mid_rst_session",    32'(session_active), 32'd0);
    check("mid_rst_lock",       32'(lock_vec), 32'd0);
    check("mid_rst_ready",      32'(req_ready), 32'd0);
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid) cyc++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (rsp_valid) cyc++;
    check("mid_rst_no_rsp", 32'(cyc), 32'd0);
    do_req(LOGIN, 0, 16'h1234, 0, st, bal, sa, lat);
    check("post_rst_status",  32'(st),  32'(OK));
    check("post_rst_balance", 32'(bal), 32'd500);
    do_req(EXT, 0, 0, 0, st, bal, sa, lat);
    do_req(LOGIN, 4, 16'h1234, 0, st, bal, sa, lat);
    check("post_rst_unlock", 32'(st), 32'(OK));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
